irq_priority_ctrl: RTL and testbench

Multi-source interrupt controller for the Nios II system. It synchronises up to NUM_SRC asynchronous event lines (ADC done, trigger, key, etc.), edge-detects each with a per-source polarity, and latches pending bits. It arbitrates masked pending sources by fixed priority, where the lowest index wins, and presents a single vectored irq. After each acknowledge it applies a programmable hold-off before the next assertion. It is an Avalon-MM slave on the CPU data bus and replaces per-source single-bit edge-capture PIOs.

---
 rtl/irq_priority_ctrl_pkg.sv | 24 ++
 rtl/irq_priority_ctrl_if.sv | 16 +
 rtl/irq_priority_ctrl_edge_sync.sv | 37 +++
 rtl/irq_priority_ctrl.sv | 160 ++++++++++++++++
 tb/tb_irq_priority_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/irq_priority_ctrl_pkg.sv
// Shared definitions for the interrupt priority controller: register word
// addresses, FSM state encoding and vector sizing.
package irq_ctrl_pkg;

    localparam int VEC_W   = 5;
    localparam int MAX_SRC = 32;

    localparam logic [2:0] ADDR_STATUS   = 3'd0;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_PENDING  = 3'd3;
    localparam logic [2:0] ADDR_VECTOR   = 3'd4;
    localparam logic [2:0] ADDR_ACK      = 3'd5;
    localparam logic [2:0] ADDR_HOLDOFF  = 3'd6;
    localparam logic [2:0] ADDR_CTRL     = 3'd7;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        ASSERT  = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

endpackage

// File: rtl/irq_priority_ctrl_if.sv
// Avalon-MM slave bus bundle for the interrupt controller.
//   address    : word address (8 registers)
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data (1-cycle latency)
interface irq_priority_ctrl_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/irq_priority_ctrl_edge_sync.sv
// One interrupt source: multi-flop synchroniser, one delay flop and a
// polarity-selected single-cycle edge pulse.
//   clk, reset_n : clock, async active-low reset
//   src_i        : asynchronous event line
//   edge_sel_i   : 1 = detect rising, 0 = detect falling
//   level_o      : synchronised level
//   edge_o       : one-cycle pulse on the selected edge
module irq_edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic src_i,
    input  logic edge_sel_i,
    output logic level_o,
    output logic edge_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   dly_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            dly_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], src_i};
            dly_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    // Only a real level change can pulse; flipping edge_sel_i while the
    // level is steady leaves both terms zero.
    assign edge_o  = edge_sel_i ? (level_o & ~dly_q) : (~level_o & dly_q);

endmodule

// File: rtl/irq_priority_ctrl.sv
// Multi-source vectored interrupt controller, Avalon-MM slave.
//   clk, reset_n : clock, async active-low reset
//   bus          : register access (STATUS, EDGE_SEL, MASK, PENDING,
//                  VECTOR, ACK, HOLDOFF, CTRL)
//   src_in       : asynchronous event lines
//   irq          : interrupt request to the CPU
//
// state   | meaning
// IDLE    | waiting for an enabled, unmasked pending source
// ARB     | latch the lowest-index candidate into VECTOR
// ASSERT  | irq high until matching ACK or the source goes away
// HOLDOFF | irq low for HOLDOFF+1 cycles after an ACK
module irq_priority_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF_W   = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    irq_priority_ctrl_if.slave  bus,
    input  logic [NUM_SRC-1:0]  src_in,
    output logic                irq
);

    logic [NUM_SRC-1:0]   level, edge_vec;
    logic [NUM_SRC-1:0]   edge_sel_q, mask_q, mask_d, pending_q, pending_d;
    logic [NUM_SRC-1:0]   clr, ack_onehot, vec_onehot, cand;
    logic                 ctrl_q, ctrl_d;
    logic [HOLDOFF_W-1:0] holdoff_q, cnt_q, cnt_d;
    logic [VEC_W-1:0]     vec_idx_q, vec_idx_d, winner;
    logic                 vec_valid_q, vec_valid_d;
    logic [31:0]          readdata_q, rd_d;
    logic                 wr_en, ack_match;
    state_e               state_q, state_d;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk        (clk),
            .reset_n    (reset_n),
            .src_i      (src_in[gi]),
            .edge_sel_i (edge_sel_q[gi]),
            .level_o    (level[gi]),
            .edge_o     (edge_vec[gi])
        );
    end

    assign wr_en  = bus.chipselect & ~bus.write_n;
    assign mask_d = (wr_en && bus.address == ADDR_MASK) ? bus.writedata[NUM_SRC-1:0] : mask_q;
    assign ctrl_d = (wr_en && bus.address == ADDR_CTRL) ? bus.writedata[0] : ctrl_q;
    assign cand   = pending_q & mask_q & {NUM_SRC{ctrl_q}};

    // ACK indices at or above NUM_SRC decode to no bit and are dropped.
    always_comb begin
        ack_onehot = '0;
        vec_onehot = '0;
        clr        = '0;
        winner     = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wr_en && bus.address == ADDR_ACK && bus.writedata[VEC_W-1:0] == VEC_W'(i))
                ack_onehot[i] = 1'b1;
            vec_onehot[i] = (vec_idx_q == VEC_W'(i));
        end
        if (wr_en && bus.address == ADDR_PENDING)
            clr = bus.writedata[NUM_SRC-1:0];
        clr = clr | ack_onehot;
        // New edges win over a same-cycle clear so no event is lost.
        pending_d = (pending_q & ~clr) | edge_vec;
        for (int i = NUM_SRC - 1; i >= 0; i--)
            if (cand[i]) winner = VEC_W'(i);
    end

    assign ack_match = |(ack_onehot & vec_onehot);

    always_comb begin
        state_d     = state_q;
        vec_idx_d   = vec_idx_q;
        vec_valid_d = vec_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: if (|cand) state_d = ARB;
            ARB: begin
                if (|cand) begin
                    vec_idx_d   = winner;
                    vec_valid_d = 1'b1;
                    state_d     = ASSERT;
                end else begin
                    vec_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            ASSERT: begin
                if (ack_match) begin
                    vec_valid_d = 1'b0;
                    cnt_d       = holdoff_q;
                    state_d     = HOLDOFF;
                // Look at next-cycle enable/mask/pending so irq falls right
                // after the disabling write lands.
                end else if (!ctrl_d || !(|(vec_onehot & mask_d & pending_d))) begin
                    vec_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            HOLDOFF: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - HOLDOFF_W'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign irq = (state_q == ASSERT);

    always_comb begin
        rd_d = '0;
        case (bus.address)
            ADDR_STATUS:   rd_d[NUM_SRC-1:0]   = level;
            ADDR_EDGE_SEL: rd_d[NUM_SRC-1:0]   = edge_sel_q;
            ADDR_MASK:     rd_d[NUM_SRC-1:0]   = mask_q;
            ADDR_PENDING:  rd_d[NUM_SRC-1:0]   = pending_q;
            ADDR_VECTOR: begin
                rd_d[31]        = vec_valid_q;
                rd_d[VEC_W-1:0] = vec_idx_q;
            end
            ADDR_HOLDOFF:  rd_d[HOLDOFF_W-1:0] = holdoff_q;
            ADDR_CTRL:     rd_d[0]             = ctrl_q;
            default:       rd_d                = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            edge_sel_q  <= '0;
            mask_q      <= '0;
            pending_q   <= '0;
            ctrl_q      <= 1'b0;
            holdoff_q   <= '0;
            cnt_q       <= '0;
            vec_idx_q   <= '0;
            vec_valid_q <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ctrl_q      <= ctrl_d;
            pending_q   <= pending_d;
            cnt_q       <= cnt_d;
            vec_idx_q   <= vec_idx_d;
            vec_valid_q <= vec_valid_d;
            readdata_q  <= rd_d;
            if (wr_en && bus.address == ADDR_EDGE_SEL) edge_sel_q <= bus.writedata[NUM_SRC-1:0];
            if (wr_en && bus.address == ADDR_HOLDOFF)  holdoff_q  <= bus.writedata[HOLDOFF_W-1:0];
        end
    end

    assign bus.readdata = readdata_q;

endmodule

// File: tb/tb_irq_priority_ctrl.sv
module tb_irq_priority_ctrl;
    import irq_ctrl_pkg::*;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [N-1:0] src_in = '0;
    logic         irq;

    irq_priority_ctrl_if bus_if();

    irq_priority_ctrl #(.NUM_SRC(N), .SYNC_STAGES(2), .HOLDOFF_W(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .src_in  (src_in),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_req = 1'b0;

    // reference model state
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_mask = '0;
    logic [N-1:0] idle_lvl = '0;
    int           m_hold = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // monitor: a read presented at a posedge returns just after that edge
    always @(posedge clk) begin
        if (rd_req) begin
            #1;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL sb_underflow: got 0x%08h expected none", bus_if.readdata);
            end else begin
                check(name_q.pop_front(), bus_if.readdata, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
        bus_if.address    = a;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
        bus_if.chipselect = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        bus_if.address    = a;
        bus_if.writedata  = d;
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        @(negedge clk);
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic wait_irq(input int max, output int cyc);
        cyc = 0;
        while (irq !== 1'b1 && cyc < max) begin
            @(negedge clk);
            cyc++;
        end
        check("irq_wait", {31'b0, irq}, 32'd1);
    endtask

    // Pulse away from idle level: leaving idle is the selected edge,
    // returning is the opposite one and is not captured.
    task automatic pulse(input logic [N-1:0] bits);
        src_in = idle_lvl ^ bits;
        idle(3);
        src_in = idle_lvl;
        idle(4);
        m_pend = m_pend | bits;
    endtask

    function automatic int lowest(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        int ex;
        logic [N-1:0] sel;
        logic [N-1:0] bits;

        bus_if.address = '0; bus_if.chipselect = 1'b0;
        bus_if.write_n = 1'b1; bus_if.writedata = '0;
        idle(3);
        reset_n = 1'b1;
        idle(2);

        // reset state
        check("irq_reset", {31'b0, irq}, 32'd0);
        for (int a = 0; a < 8; a++) rd(3'(a), 32'd0, $sformatf("reset_read_a%0d", a));

        // single falling-edge source, exact latency
        idle_lvl = '1; src_in = idle_lvl;
        idle(4);
        rd(ADDR_STATUS, 32'hFF, "status_idle_high");
        wr(ADDR_MASK, 32'h01);
        wr(ADDR_CTRL, 32'h1);
        src_in[0] = 1'b0;
        idle(2);
        rd(ADDR_PENDING, 32'h0, "pend_before_3rd_edge");
        rd(ADDR_PENDING, 32'h1, "pend_at_3rd_edge");
        check("irq_not_yet", {31'b0, irq}, 32'd0);
        idle(1);
        check("irq_two_after_pend", {31'b0, irq}, 32'd1);
        rd(ADDR_VECTOR, 32'h8000_0000, "vector_src0");
        src_in[0] = 1'b1;
        idle(4);
        wr(ADDR_ACK, 32'd0);
        rd(ADDR_PENDING, 32'h0, "pend_after_ack0");
        idle(4);
        check("irq_low_after_ack0", {31'b0, irq}, 32'd0);

        // two simultaneous sources, priority, hold-off, no pre-emption
        m_pend = '0;
        wr(ADDR_MASK, 32'hFF);
        wr(ADDR_HOLDOFF, 32'd10);
        pulse(8'h24);
        rd(ADDR_PENDING, 32'h24, "pend_5_and_2");
        wait_irq(20, c);
        rd(ADDR_VECTOR, 32'h8000_0002, "vector_2_first");
        wr(ADDR_ACK, 32'd31);
        wr(ADDR_ACK, 32'd9);
        check("ack_out_of_range_ignored", {31'b0, irq}, 32'd1);
        rd(ADDR_PENDING, 32'h24, "pend_after_bad_ack");
        wr(ADDR_ACK, 32'd2);
        rd(ADDR_PENDING, 32'h20, "pend_after_ack2");
        wait_irq(100, c);
        check("holdoff10_spacing", 32'(c + 1), 32'd13);
        rd(ADDR_VECTOR, 32'h8000_0005, "vector_5_second");
        pulse(8'h02);
        check("no_preempt_irq", {31'b0, irq}, 32'd1);
        rd(ADDR_VECTOR, 32'h8000_0005, "no_preempt_vector");
        wr(ADDR_ACK, 32'd5);
        wait_irq(100, c);
        check("holdoff10_spacing_b", 32'(c), 32'd13);
        rd(ADDR_VECTOR, 32'h8000_0001, "vector_1_after_5");
        wr(ADDR_ACK, 32'd1);
        idle(15);
        check("irq_low_all_done", {31'b0, irq}, 32'd0);
        rd(ADDR_PENDING, 32'h0, "pend_all_clear");

        // W1C colliding with a new edge on the same bit
        wr(ADDR_CTRL, 32'h0);
        pulse(8'h02);
        rd(ADDR_PENDING, 32'h02, "pend_bit1_set");
        src_in[1] = 1'b0;
        idle(2);
        wr(ADDR_PENDING, 32'h02);
        src_in[1] = 1'b1;
        idle(4);
        rd(ADDR_PENDING, 32'h02, "w1c_collision_set_wins");
        wr(ADDR_PENDING, 32'h02);
        rd(ADDR_PENDING, 32'h0, "w1c_plain_clear");

        // global disable / mask drop during ASSERT, then reset mid-holdoff
        wr(ADDR_CTRL, 32'h1);
        pulse(8'h10);
        wait_irq(20, c);
        wr(ADDR_CTRL, 32'h0);
        check("irq_drop_ctrl", {31'b0, irq}, 32'd0);
        rd(ADDR_VECTOR, 32'h0000_0004, "vector_invalid_ctrl_off");
        wr(ADDR_CTRL, 32'h1);
        wait_irq(20, c);
        rd(ADDR_VECTOR, 32'h8000_0004, "vector_reassert_same");
        wr(ADDR_MASK, 32'hEF);
        check("irq_drop_mask", {31'b0, irq}, 32'd0);
        wr(ADDR_MASK, 32'hFF);
        wait_irq(20, c);
        wr(ADDR_ACK, 32'd4);
        idle(4);
        reset_n = 1'b0;
        #1;
        check("irq_async_reset", {31'b0, irq}, 32'd0);
        check("readdata_async_reset", bus_if.readdata, 32'd0);
        idle(2);
        reset_n = 1'b1;
        idle(4);
        rd(ADDR_STATUS,   32'hFF, "post_reset_status");
        rd(ADDR_EDGE_SEL, 32'h0,  "post_reset_edge_sel");
        rd(ADDR_MASK,     32'h0,  "post_reset_mask");
        rd(ADDR_PENDING,  32'h0,  "post_reset_pending");
        rd(ADDR_VECTOR,   32'h0,  "post_reset_vector");
        rd(ADDR_HOLDOFF,  32'h0,  "post_reset_holdoff");
        rd(ADDR_CTRL,     32'h0,  "post_reset_ctrl");

        // randomized rounds against the set/priority model
        m_pend = '0;
        for (int r = 0; r < 6; r++) begin
            wr(ADDR_CTRL, 32'h0);
            sel = N'($urandom);
            wr(ADDR_EDGE_SEL, 32'(sel));
            idle_lvl = ~sel;
            src_in = idle_lvl;
            idle(5);
            m_mask = (r == 0) ? '1 : N'($urandom);
            wr(ADDR_MASK, 32'(m_mask));
            m_hold = $urandom_range(0, 6);
            wr(ADDR_HOLDOFF, 32'(m_hold));
            bits = N'($urandom);
            pulse(bits);
            rd(ADDR_PENDING, 32'(m_pend), $sformatf("rnd%0d_pending", r));
            rd(ADDR_STATUS, 32'(idle_lvl), $sformatf("rnd%0d_status", r));
            wr(ADDR_CTRL, 32'h1);
            for (int k = 0; k < N && (m_pend & m_mask) != '0; k++) begin
                ex = lowest(m_pend & m_mask);
                wait_irq(50, c);
                if (k != 0) check($sformatf("rnd%0d_spacing", r), 32'(c), 32'(m_hold + 3));
                rd(ADDR_VECTOR, 32'h8000_0000 | 32'(ex), $sformatf("rnd%0d_vector", r));
                wr(ADDR_ACK, 32'(ex));
                m_pend[ex] = 1'b0;
            end
            idle(m_hold + 6);
            check($sformatf("rnd%0d_irq_quiet", r), {31'b0, irq}, 32'd0);
            rd(ADDR_PENDING, 32'(m_pend), $sformatf("rnd%0d_masked_left", r));
            wr(ADDR_PENDING, 32'hFF);
            m_pend = '0;
            rd(ADDR_PENDING, 32'h0, $sformatf("rnd%0d_w1c_all", r));
        end

        idle(3);
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
